atmega_spi_s: RTL
=================

Name: atmega_spi_s

Overview:
ATmega-compatible SPI slave peripheral. It is the responder for the team's SPI master, so a soft AVR core can act as the target of an external SPI master (for example, a host MCU or a test harness). The CPU sees the same SPCR/SPSR/SPDR register window and interrupt semantics as the master. SCK, SS_n and MOSI are asynchronous inputs that are synchronised and edge-detected in the clk domain.

Parameters:
BUS_ADDR_DATA_LEN, 8, width of addr_dat
SPCR_ADDR, 'h20, control register address
SPSR_ADDR, 'h21, status register address
SPDR_ADDR, 'h22, data register address
SYNC_STAGES, 2, synchroniser depth for sck/ss_n/mosi (legal range 2..3)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
addr_dat  in  BUS_ADDR_DATA_LEN  register address
wr_dat  in  1  register write strobe
rd_dat  in  1  register read strobe
bus_dat_in  in  8  write data
bus_dat_out  out  8  read data; combinational, 0 when rd_dat=0 or address unmatched
int_out  out  1  SPIF & SPCR[7]
int_rst  in  1  interrupt acknowledge; clears SPIF
io_connect  out  1  SPCR[6] (EN)
sck  in  1  external SPI clock (async)
ss_n  in  1  external slave select, active-low (async)
mosi  in  1  external data in (async)
miso  out  1  serial data out
miso_oe  out  1  output enable = EN & ~MSTR & ss_n_synced low

Behaviour:
- Reset (rst low): SPCR=0, SPSR=0, rx_buf=0, tx_hold=0, tx_shift=0, rx_shift=0, bit_cnt=0. Synchroniser flops reset to sck=CPOL-idle 0, ss_n=1, mosi=0. Outputs: miso=1, miso_oe=0, int_out=0.
- SPCR bits: 7 SPIE, 6 SPE, 5 DORD, 3 CPOL, 2 CPHA; bits 4,1,0 are stored and readable, and bits 1/0 have no effect.
- Synchronisation: SYNC_STAGES flops per input, plus one delay flop on sck for edge detect.
  - Input-to-internal-event latency is SYNC_STAGES+1 clk.
  - clk must be ≥4× sck; faster sck is out of spec.
- Edges: lead edge = rising if CPOL=0, falling if CPOL=1; trail edge is the opposite.
  - CPHA=0: sample on lead, shift out on trail.
  - CPHA=1: shift out on lead (except the first lead of a byte, which only starts the bit), sample on trail.
- Sample: rx_shift <= DORD ? {mosi,rx_shift[7:1]} : {rx_shift[6:0],mosi}; bit_cnt++.
- Shift out: tx_shift shifts toward the output bit, filling with 1.
- miso = DORD ? tx_shift[0] : tx_shift[7]. It is forced to 1 when miso_oe=0.
- State machine:
  - IDLE: ss_n high or SPE=0.
  - ss_n synced falling edge with SPE=1 and MSTR=0: tx_shift <= tx_hold, bit_cnt=0, go to ACTIVE.
  - ACTIVE → IDLE: on ss_n rising, or when SPE is cleared.
- Byte complete (8th sample):
  - rx_buf <= assembled byte and SPIF <= 1, both in the same cycle.
  - bit_cnt <= 0.
  - tx_shift reloads from tx_hold for the next byte; tx_hold keeps its value.
- ss_n rising mid-byte (bit_cnt 1..7):
  - Partial byte discarded; bit_cnt=0.
  - No SPIF; rx_buf unchanged.
- SPDR write:
  - In IDLE, or in ACTIVE with bit_cnt=0 and no edge pending: tx_hold <= bus_dat_in. If IDLE, the load into tx_shift happens at the next SS fall.
  - Otherwise: write ignored, SPSR[6] WCOL <= 1.
- SPDR read returns rx_buf.
- SPSR read returns {SPIF, WCOL, OVR_or_0, 5'b0}. The read clears SPIF and WCOL on the same clk.
- SPSR write: writable bits are ignored (the status bits are read-only).
- Simultaneous events on one clk: SPIF set (byte complete) beats a clear (int_rst or SPSR read). int_rst and SPSR-read clears are equivalent.
- SPCR write takes effect on the next clk. Changing CPOL/CPHA/DORD mid-byte is undefined but must not lock up; the next SS fall resynchronises.

Optional Feature:
ATMEGA_SPI_S_OVERRUN_EN.
- Defined: SPSR[5] OVR is set when a byte completes while SPIF is still 1. rx_buf is overwritten with the newest byte. OVR clears together with SPIF (SPSR read or int_rst); if set and clear coincide, set wins.
- Undefined: SPSR[5] reads 0 and no OVR logic is generated.

Test Plan:
- Mode 0, MSB first: SPCR=0x40, tx_hold=0xA5. Master sends 0x3C → miso bits 1,0,1,0,0,1,0,1; SPDR read =0x3C; SPIF=1; int_out=0.
- Mode 3, LSB first, SPIE: SPCR=0xED, tx_hold=0x81, master sends 0x12 → miso LSB first; SPDR=0x12; int_out=1 until int_rst pulse, then 0.
- Two back-to-back bytes 0x55, 0xAA without SS release → SPIF set after each byte; SPDR=0xAA after the second; the second byte's miso is tx_hold again.
- WCOL: SPDR write of 0x77 at bit_cnt=3 → SPSR=0x40 after the byte completes plus SPIF (0xC0); tx_hold unchanged; SPSR read → next SPSR read returns 0x00.
- Abort: ss_n rises after 5 bits → SPIF stays 0; rx_buf keeps its previous value 0x3C; the next full byte 0xF0 is received correctly.
- Reset mid-transfer: rst low at bit 4 → miso=1, miso_oe=0, SPCR=SPSR=0 immediately (async). With the overrun macro defined, two bytes without clearing SPIF → SPSR=0xA0.

Source files
------------

// File: rtl/atmega_spi_s_if.sv
// Register-bus interface for the SPI slave: CPU-side
// address/strobe/data plus interrupt request and acknowledge.
interface atmega_spi_s_if #(
  parameter int BUS_ADDR_DATA_LEN = 8
);
  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat;
  logic                         wr_dat;
  logic                         rd_dat;
  logic [7:0]                   bus_dat_in;
  logic [7:0]                   bus_dat_out;
  logic                         int_out;
  logic                         int_rst;

  modport master (
    output addr_dat, wr_dat, rd_dat,
    output bus_dat_in, int_rst,
    input  bus_dat_out, int_out
  );

  modport slave (
    input  addr_dat, wr_dat, rd_dat,
    input  bus_dat_in, int_rst,
    output bus_dat_out, int_out
  );
endinterface

// File: rtl/atmega_spi_s.sv
// ATmega-style SPI slave: SPCR/SPSR/SPDR window on bus (slave
// modport), sck/ss_n/mosi synchronised in, miso/miso_oe out.
// clk, rst (async active-low), io_connect = SPCR.SPE.
// ATMEGA_SPI_S_OVERRUN_EN adds SPSR.OVR (overrun flag).
module atmega_spi_s #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR = 'h20,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR = 'h21,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR = 'h22,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  atmega_spi_s_if.slave bus,
  output logic io_connect,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic sck_d, ss_d;
  logic [7:0] spcr, rx_buf, tx_hold;
  logic [7:0] tx_shift, rx_shift;
  logic [2:0] bit_cnt;
  logic spif, wcol, ovr;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic spie, en, dord, mstr, cpol, cpha;
  logic lead, trail, go, stop, run;
  logic smp, sft, done;
  logic spcr_wr, spdr_wr, spsr_rd;
  logic spdr_ok, wcol_set, clr;
  logic [7:0] rx_next, tx_next;

  assign spie = spcr[7];
  assign en   = spcr[6];
  assign dord = spcr[5];
  assign mstr = spcr[4];
  assign cpol = spcr[3];
  assign cpha = spcr[2];

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign ss_s   = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_s;
      ss_d   <= ss_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;

  assign lead  = cpol ? sck_fall : sck_rise;
  assign trail = cpol ? sck_rise : sck_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (ss_fall && en && !mstr)
          state_d = ACTIVE;
      ACTIVE:
        if (ss_rise || !en)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign go   = (state_q == IDLE) &&
                (state_d == ACTIVE);
  assign stop = (state_q == ACTIVE) &&
                (state_d == IDLE);
  assign run  = (state_q == ACTIVE) && !stop;

  // bit_cnt==0 marks "between bytes": the trail after the 8th
  // sample (CPHA=0) and the first lead (CPHA=1) must not shift.
  assign smp  = run && (cpha ? trail : lead);
  assign sft  = run && (cpha ? lead : trail) &&
                (bit_cnt != 3'd0);
  assign done = smp && (bit_cnt == 3'd7);

  assign rx_next = dord ? {mosi_s, rx_shift[7:1]}
                        : {rx_shift[6:0], mosi_s};
  assign tx_next = dord ? {1'b1, tx_shift[7:1]}
                        : {tx_shift[6:0], 1'b1};

  assign spcr_wr = bus.wr_dat &&
                   (bus.addr_dat == SPCR_ADDR);
  assign spdr_wr = bus.wr_dat &&
                   (bus.addr_dat == SPDR_ADDR);
  assign spsr_rd = bus.rd_dat &&
                   (bus.addr_dat == SPSR_ADDR);

  assign spdr_ok  = (state_q == IDLE) ||
                    ((bit_cnt == 3'd0) && (sck_s == sck_d));
  assign wcol_set = spdr_wr && !spdr_ok;
  assign clr      = bus.int_rst || spsr_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spcr     <= '0;
      rx_buf   <= '0;
      tx_hold  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      if (spcr_wr) spcr <= bus.bus_dat_in;
      if (state_q == IDLE) begin
        bit_cnt <= '0;
        if (go) begin
          tx_shift <= tx_hold;
          rx_shift <= '0;
        end
      end else if (stop) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (smp) begin
        rx_shift <= rx_next;
        if (done) begin
          rx_buf   <= rx_next;
          bit_cnt  <= '0;
          tx_shift <= tx_hold;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (sft) begin
        tx_shift <= tx_next;
      end
      // An accepted write between bytes goes straight to
      // the shifter so the next byte carries it.
      if (spdr_wr && spdr_ok) begin
        tx_hold <= bus.bus_dat_in;
        if (state_q == ACTIVE || go)
          tx_shift <= bus.bus_dat_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spif <= 1'b0;
      wcol <= 1'b0;
    end else begin
      if (done)     spif <= 1'b1;
      else if (clr) spif <= 1'b0;
      if (wcol_set)     wcol <= 1'b1;
      else if (spsr_rd) wcol <= 1'b0;
    end
  end

`ifdef ATMEGA_SPI_S_OVERRUN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             ovr <= 1'b0;
    else if (done && spif) ovr <= 1'b1;
    else if (clr)          ovr <= 1'b0;
  end
`else
  assign ovr = 1'b0;
`endif

  always_comb begin
    bus.bus_dat_out = '0;
    if (bus.rd_dat) begin
      if (bus.addr_dat == SPCR_ADDR)
        bus.bus_dat_out = spcr;
      else if (bus.addr_dat == SPSR_ADDR)
        bus.bus_dat_out = {spif, wcol, ovr, 5'b0};
      else if (bus.addr_dat == SPDR_ADDR)
        bus.bus_dat_out = rx_buf;
    end
  end

  assign bus.int_out = spif & spie;
  assign io_connect  = en;
  assign miso_oe     = en & ~mstr & ~ss_s;
  assign miso        = miso_oe ?
                       (dord ? tx_shift[0] : tx_shift[7]) :
                       1'b1;

endmodule
